if_fetch_pc_gen: RTL and testbench
==================================

Name: if_fetch_pc_gen

Overview:
- Next-generation IF0 fetch-address generator.
- Owns the fetch PC and issues fetch-group requests to the I-cache with a valid/addr_ok handshake.
- Forms a per-slot valid/taken mask from BPU hints and buffers accepted requests in a DEPTH-entry queue toward IF1 with valid/ready.
- Supports FETCH_WIDTH instructions per group, multiple requests in flight, and epoch tagging so IF1 can discard stale cache responses after a redirect.

Parameters:
- FETCH_WIDTH, 4: instructions per fetch group; power of 2, range 1..8.
- DEPTH, 4: request queue entries; power of 2, at least 2.
- RESET_PC, 32'h1c000000: PC after reset.
- EPOCH_W, 2: epoch tag width.
- UNC_BASE, 32'h1fe00000: uncached window base (optional feature only).
- UNC_MASK, 32'hfff00000: uncached window compare mask (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- redirect_valid  in  1  backend/branch redirect
- redirect_pc  in  32  redirect target
- req_valid  out  1  fetch request to I-cache
- req_addr  out  32  current fetch PC
- req_uncached  out  1  uncached attribute
- req_addr_ok  in  1  cache accepts request this cycle
- bpu_pc  out  32  PC presented to BPU (equals req_addr)
- bpu_taken  in  FETCH_WIDTH  predicted-taken per slot
- bpu_target  in  32  predicted target
- out_valid  out  1  queue head valid
- out_ready  in  1  IF1 accepts head
- out_pc  out  32  head fetch PC
- out_slot_valid  out  FETCH_WIDTH  head slot-valid mask
- out_taken  out  FETCH_WIDTH  head taken mask
- out_epoch  out  EPOCH_W  head epoch tag
- cur_epoch  out  EPOCH_W  live epoch for IF1 stale-response compare

Behaviour:
- Slot numbering: slot i = bit i, address base+4*i. base = pc with the low log2(FETCH_WIDTH)+2 bits cleared. off = pc[log2(FETCH_WIDTH)+1:2].
- Slot mask: slots off..FETCH_WIDTH-1 are valid, truncated after the lowest valid slot with bpu_taken set.
- out_taken: only that lowest taken slot is set; all zero if none.
- Next PC: bpu_target if any valid slot is taken, else base+FETCH_WIDTH*4. Arithmetic is modulo 2^32.
- req_valid = !rst && !redirect_valid && count<DEPTH.
- Accept = req_valid && req_addr_ok. On accept: push {pc, mask, taken, epoch}; pc <= next PC.
- Redirect has highest priority: pc <= redirect_pc, queue cleared (count=0), epoch <= epoch+1 (wraps). An accept in the same cycle is dropped, never pushed.
- Queue is FWFT.
  - Latency: accept in cycle N -> out_valid in N+1 if the queue was empty.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged. This is legal when full only if the push was permitted, and it is not, since req_valid requires count<DEPTH.
- Full: req_valid=0 and pc held. Empty: out_valid=0; out_* hold last values (don't-care).
- Reset values: pc=RESET_PC, count=0, rd/wr pointers=0, epoch=0, out_valid=0, req_valid=0, out masks=0, req_uncached=0.
- Reset mid-operation discards all entries. The first req_valid is in the cycle after rst deasserts.

Optional Feature:
- Macro IF_UNCACHED_WIN_EN.
- Defined: req_uncached = ((req_addr & UNC_MASK) == (UNC_BASE & UNC_MASK)). An uncached group forces the slot mask to the single slot off and taken to that slot's bpu_taken only. Next PC is then pc+4, or bpu_target if taken.
- Undefined: req_uncached tied 0; UNC_* are unused.

Decomposition:
- Shared package if_pkg:
  - constants: INST_BYTES=4, default RESET_PC
  - typedef if_req_entry_t {pc, slot_valid, taken, epoch}
  - helper function for slot-mask generation
- One sub-module if_pc_fifo: parametrised FWFT queue (DEPTH, entry width) with sync clear, count, full/empty.

Test Plan:
1. Reset, addr_ok=1, bpu_taken=0, out_ready=1 -> req_addr 0x1c000000, out_slot_valid 4'b1111, next req_addr 0x1c000010, out_valid one cycle after accept.
2. redirect_pc=0x1c000008, no taken -> out_slot_valid 4'b1100, next req_addr 0x1c000010.
3. pc=0x1c000000, bpu_taken=4'b1010, bpu_target=0x1c000100 -> out_slot_valid 4'b0011, out_taken 4'b0010, next req_addr 0x1c000100.
4. out_ready=0, addr_ok=1 -> four accepts, then req_valid=0 and pc held. One pop -> req_valid=1 next cycle.
5. redirect_valid with addr_ok=1 and 3 entries queued -> no push, out_valid=0 next cycle, cur_epoch 0->1, req_addr=redirect_pc. Four redirects wrap the epoch to 0.
6. IF_UNCACHED_WIN_EN defined, redirect to 0x1fe00004 -> req_uncached=1, out_slot_valid 4'b0010, next req_addr 0x1fe00008.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared constants, request-entry layout and slot-mask helper for the IF0 fetch stage.
// Contents:
//   INST_BYTES      bytes per instruction slot
//   DEF_RESET_PC    default fetch PC after reset
//   if_req_entry_t  queue entry {pc, slot_valid, taken, epoch}, sized for the widest configuration
//   slot_step       one slot of the valid/taken mask chain
package if_pkg;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h1c000000;
    localparam int FW_MAX = 8;
    localparam int EW_MAX = 8;

    typedef struct packed {
        logic [31:0]       pc;
        logic [FW_MAX-1:0] slot_valid;
        logic [FW_MAX-1:0] taken;
        logic [EW_MAX-1:0] epoch;
    } if_req_entry_t;

    // Returns {slot_valid, slot_taken, hit_out}; once a taken slot is seen, later slots are dropped.
    function automatic logic [2:0] slot_step(input logic live, input logic tk, input logic hit);
        logic v;
        v = live && !hit;
        return {v, v && tk, hit || (v && tk)};
    endfunction
endpackage

// File: rtl/if_pc_fifo.sv
// if_pc_fifo: first-word-fall-through request queue with synchronous clear.
// Ports:
//   clk, rst       clock, synchronous active-high reset (also zeroes storage)
//   clr            drop all entries
//   push, din      write an entry (ignored when full)
//   pop            consume the head (ignored when empty)
//   dout           head entry, valid whenever !empty
//   count, empty   occupancy and empty flag
module if_pc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic          full, do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/if_fetch_pc_gen.sv
// if_fetch_pc_gen: IF0 fetch-address generator; owns the fetch PC, issues I-cache requests and
// queues accepted fetch groups (PC, slot mask, taken mask, epoch) toward IF1.
// Optional uncached window enabled by macro IF_UNCACHED_WIN_EN.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   redirect: new PC, flush queue, bump epoch
//   req_valid, req_addr,
//   req_uncached, req_addr_ok     I-cache request handshake
//   bpu_pc, bpu_taken, bpu_target branch-predictor lookup and hints
//   out_valid, out_ready, out_pc,
//   out_slot_valid, out_taken,
//   out_epoch                     FWFT queue head toward IF1
//   cur_epoch                     live epoch for stale-response filtering
module if_fetch_pc_gen
    import if_pkg::*;
#(
    parameter int          FETCH_WIDTH = 4,
    parameter int          DEPTH       = 4,
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter int          EPOCH_W     = 2
`ifdef IF_UNCACHED_WIN_EN
   ,parameter logic [31:0] UNC_BASE    = 32'h1fe00000,
    parameter logic [31:0] UNC_MASK    = 32'hfff00000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   req_valid,
    output logic [31:0]            req_addr,
    output logic                   req_uncached,
    input  logic                   req_addr_ok,
    output logic [31:0]            bpu_pc,
    input  logic [FETCH_WIDTH-1:0] bpu_taken,
    input  logic [31:0]            bpu_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [FETCH_WIDTH-1:0] out_slot_valid,
    output logic [FETCH_WIDTH-1:0] out_taken,
    output logic [EPOCH_W-1:0]     out_epoch,
    output logic [EPOCH_W-1:0]     cur_epoch
);
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int QW        = 32 + 2*FETCH_WIDTH + EPOCH_W;
    localparam int GRP_BYTES = FETCH_WIDTH * INST_BYTES;

    logic [31:0]            pc, base, off, next_pc;
    logic [EPOCH_W-1:0]     epoch;
    logic [FETCH_WIDTH-1:0] slot_valid, taken;
    logic [2:0]             st;
    logic [CW-1:0]          count;
    logic [QW-1:0]          q_dout;
    logic                   unc, hit, accept, empty;

    assign base = pc & ~32'(GRP_BYTES - 1);
    // Shift-and-mask keeps FETCH_WIDTH=1 legal (offset is always 0 there).
    assign off  = (pc >> 2) & 32'(FETCH_WIDTH - 1);

`ifdef IF_UNCACHED_WIN_EN
    assign unc = (pc & UNC_MASK) == (UNC_BASE & UNC_MASK);
`else
    assign unc = 1'b0;
`endif

    // Uncached groups fetch only the addressed slot; cached groups fetch off..end.
    always_comb begin
        slot_valid = '0;
        taken      = '0;
        hit        = 1'b0;
        st         = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            st            = slot_step(unc ? 32'(i) == off : 32'(i) >= off, bpu_taken[i], hit);
            slot_valid[i] = st[2];
            taken[i]      = st[1];
            hit           = st[0];
        end
    end

    assign next_pc = hit ? bpu_target : unc ? pc + 32'(INST_BYTES) : base + 32'(GRP_BYTES);

    assign req_valid    = !rst && !redirect_valid && count < CW'(DEPTH);
    assign accept       = req_valid && req_addr_ok;
    assign req_addr     = pc;
    assign bpu_pc       = pc;
    assign req_uncached = unc;
    assign cur_epoch    = epoch;
    assign out_valid    = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            epoch <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            epoch <= epoch + 1'b1;
        end else if (accept) begin
            pc    <= next_pc;
        end
    end

    // A redirect clears the queue; the same-cycle accept is already masked by req_valid.
    if_pc_fifo #(.DEPTH(DEPTH), .W(QW)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (redirect_valid),
        .push (accept),
        .din  ({pc, slot_valid, taken, epoch}),
        .pop  (out_valid && out_ready),
        .dout (q_dout),
        .count(count),
        .empty(empty)
    );

    assign {out_pc, out_slot_valid, out_taken, out_epoch} = q_dout;
endmodule

// File: tb/tb_if_fetch_pc_gen.sv
// tb_if_fetch_pc_gen: table-driven and scoreboard bench for the IF0 fetch-address generator.
module tb_if_fetch_pc_gen;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid, req_uncached;
    logic [31:0] req_addr, bpu_pc, out_pc;
    logic        req_addr_ok = 1'b0;
    logic [3:0]  bpu_taken = '0;
    logic [31:0] bpu_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_slot_valid, out_taken;
    logic [1:0]  out_epoch, cur_epoch;

    always #5 clk = ~clk;

    if_fetch_pc_gen dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_addr(req_addr), .req_uncached(req_uncached),
        .req_addr_ok(req_addr_ok),
        .bpu_pc(bpu_pc), .bpu_taken(bpu_taken), .bpu_target(bpu_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_slot_valid(out_slot_valid), .out_taken(out_taken), .out_epoch(out_epoch),
        .cur_epoch(cur_epoch)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  tk_in;
        logic [31:0] tgt;
        logic [3:0]  slot;
        logic [3:0]  tk;
        logic [31:0] nxt;
        logic        unc;
    } vec_t;

    vec_t          vecs[$];
    if_req_entry_t exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [31:0]   mpc;
    logic [1:0]    ep;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : sb
        if_req_entry_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                chk("sb_entry", 64'({out_pc, 8'(out_slot_valid), 8'(out_taken), 8'(out_epoch)}), 64'(e));
            end
        end
    end

    task automatic redirect(input logic [31:0] p);
        redirect_valid = 1'b1;
        redirect_pc    = p;
        req_addr_ok    = 1'b1;
        #1 chk("redir_no_req", 64'(req_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        req_addr_ok    = 1'b0;
        ep++;
        exp_q.delete();
        mpc = p;
        #1;
        chk("redir_pc", 64'(req_addr), 64'(p));
        chk("redir_epoch", 64'(cur_epoch), 64'(ep));
        chk("redir_flush", 64'(out_valid), 64'd0);
    endtask

    task automatic fetch(input logic [3:0] tk_in, input logic [31:0] tgt, input logic [3:0] slot,
                         input logic [3:0] tk, input logic [31:0] nxt);
        bpu_taken   = tk_in;
        bpu_target  = tgt;
        req_addr_ok = 1'b1;
        #1;
        chk("fetch_req_valid", 64'(req_valid), 64'd1);
        chk("fetch_addr", 64'(req_addr), 64'(mpc));
        chk("bpu_pc", 64'(bpu_pc), 64'(mpc));
        exp_q.push_back(if_req_entry_t'{pc: mpc, slot_valid: 8'(slot), taken: 8'(tk), epoch: 8'(ep)});
        step();
        req_addr_ok = 1'b0;
        mpc = nxt;
        #1;
        chk("next_pc", 64'(req_addr), 64'(nxt));
        chk("out_valid_lat", 64'(out_valid), 64'd1);
    endtask

    initial begin
        vecs.push_back('{32'h1c000000, 4'b0000, 32'h0,        4'b1111, 4'b0000, 32'h1c000010, 1'b0});
        vecs.push_back('{32'h1c000008, 4'b0000, 32'h0,        4'b1100, 4'b0000, 32'h1c000010, 1'b0});
        vecs.push_back('{32'h1c000000, 4'b1010, 32'h1c000100, 4'b0011, 4'b0010, 32'h1c000100, 1'b0});
        vecs.push_back('{32'h1c000004, 4'b0001, 32'h1c000200, 4'b1110, 4'b0000, 32'h1c000010, 1'b0});
        vecs.push_back('{32'h1c00000c, 4'b1000, 32'h1c000300, 4'b1000, 4'b1000, 32'h1c000300, 1'b0});
        vecs.push_back('{32'hfffffff0, 4'b0000, 32'h0,        4'b1111, 4'b0000, 32'h00000000, 1'b0});
        vecs.push_back('{32'h1c000004, 4'b0110, 32'h1c000040, 4'b0010, 4'b0010, 32'h1c000040, 1'b0});
        vecs.push_back('{32'h1c00000c, 4'b0000, 32'h0,        4'b1000, 4'b0000, 32'h1c000010, 1'b0});
`ifdef IF_UNCACHED_WIN_EN
        vecs.push_back('{32'h1fe00004, 4'b0000, 32'h0,        4'b0010, 4'b0000, 32'h1fe00008, 1'b1});
        vecs.push_back('{32'h1fe00008, 4'b0100, 32'h1c000000, 4'b0100, 4'b0100, 32'h1c000000, 1'b1});
        vecs.push_back('{32'h1fe0000c, 4'b0001, 32'h1c000000, 4'b1000, 4'b0000, 32'h1fe00010, 1'b1});
`endif
        step();
        step();
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_slot_valid", 64'(out_slot_valid), 64'd0);
        chk("rst_taken", 64'(out_taken), 64'd0);
        chk("rst_uncached", 64'(req_uncached), 64'd0);
        chk("rst_epoch", 64'(cur_epoch), 64'd0);
        chk("rst_pc", 64'(req_addr), 64'h1c000000);

        rst       = 1'b0;
        mpc       = 32'h1c000000;
        ep        = 2'd0;
        out_ready = 1'b1;
        fetch(4'b0000, 32'h0, 4'b1111, 4'b0000, 32'h1c000010);

        foreach (vecs[k]) begin
            redirect(vecs[k].pc);
            chk("uncached", 64'(req_uncached), 64'(vecs[k].unc));
            fetch(vecs[k].tk_in, vecs[k].tgt, vecs[k].slot, vecs[k].tk, vecs[k].nxt);
        end

        redirect(32'h1c000000);
        out_ready = 1'b0;
        repeat (4) fetch(4'b0000, 32'h0, 4'b1111, 4'b0000, mpc + 32'd16);
        req_addr_ok = 1'b1;
        #1 chk("full_stall", 64'(req_valid), 64'd0);
        step();
        chk("full_hold", 64'(req_addr), 64'(mpc));
        chk("full_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready   = 1'b0;
        req_addr_ok = 1'b0;
        #1;
        chk("refill_req_valid", 64'(req_valid), 64'd1);
        chk("refill_hold", 64'(req_addr), 64'(mpc));

        redirect(32'h1c000040);
        redirect(32'h1c000080);
        redirect(32'h1c0000c4);
        redirect(32'h1c000100);

        fetch(4'b0000, 32'h0, 4'b1111, 4'b0000, 32'h1c000110);
        fetch(4'b0000, 32'h0, 4'b1111, 4'b0000, 32'h1c000120);
        rst = 1'b1;
        #1 chk("midrst_req_valid", 64'(req_valid), 64'd0);
        step();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_pc", 64'(req_addr), 64'h1c000000);
        chk("midrst_epoch", 64'(cur_epoch), 64'd0);
        exp_q.delete();
        ep  = 2'd0;
        mpc = 32'h1c000000;
        rst = 1'b0;
        #1 chk("post_rst_req_valid", 64'(req_valid), 64'd1);
        out_ready = 1'b1;
        fetch(4'b0000, 32'h0, 4'b1111, 4'b0000, 32'h1c000010);
        step();
        step();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
